// File: rtl/ram_arbiter.sv
// Purpose: round-robin arbiter sharing one synchronous single-port data RAM between
//          the control unit (port A) and the host/DMA loader (port B), with bounded burst lock.
// Latency: grant and RAM command registered 1 cycle after the deciding edge; read data 1 cycle after grant.
// Backpressure: a requester holds req until it sees its gnt pulse; the loser of a tie simply waits.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-low reset
//   a_* / b_*             request, lock, write enable, address, write data in; gnt and rvalid out
//   rdata                 read data (pass-through of ram_dout), qualified by a_rvalid / b_rvalid
//   ram_we/ram_addr/ram_din  registered RAM command; ram_dout is the RAM's registered read data
module ram_arbiter #(
    parameter int RAM_SIZE  = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_req,
    input  logic                a_lock,
    input  logic                a_we,
    input  logic [RAM_SIZE-1:0] a_addr,
    input  logic [15:0]         a_wdata,
    output logic                a_gnt,
    output logic                a_rvalid,
    input  logic                b_req,
    input  logic                b_lock,
    input  logic                b_we,
    input  logic [RAM_SIZE-1:0] b_addr,
    input  logic [15:0]         b_wdata,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [15:0]         rdata,
    output logic                ram_we,
    output logic [RAM_SIZE-1:0] ram_addr,
    output logic [15:0]         ram_din,
    input  logic [15:0]         ram_dout
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    owner_e     last_owner;
    owner_e     next_owner;
    logic [3:0] burst_cnt;
    logic [3:0] next_cnt;
    logic       grant_a;
    logic       grant_b;
    logic       owner_req;
    logic       owner_lock;
    logic       lock_hold;

    // Only the current owner's lock matters; a lock raised by the other port is ignored.
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        next_owner = last_owner;
        next_cnt   = burst_cnt;
        owner_req  = (last_owner == OWNER_A) ? a_req  : b_req;
        owner_lock = (last_owner == OWNER_A) ? a_lock : b_lock;
        lock_hold  = owner_req && owner_lock && (burst_cnt < BURST_LIMIT);

        if (a_req && b_req) begin
            if (lock_hold) begin
                grant_a = (last_owner == OWNER_A);
                grant_b = (last_owner == OWNER_B);
            end else begin
                grant_a = (last_owner == OWNER_B);
                grant_b = (last_owner == OWNER_A);
            end
        end else begin
            grant_a = a_req;
            grant_b = b_req;
        end

        if (grant_a || grant_b) begin
            next_owner = grant_a ? OWNER_A : OWNER_B;
            if (next_owner != last_owner) begin
                next_cnt = 4'd1;
            end else if (burst_cnt < BURST_LIMIT) begin
                next_cnt = burst_cnt + 4'd1;
            end
        end else begin
            // An idle cycle ends any burst so the next lock starts with a full allowance.
            next_cnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_gnt      <= 1'b0;
            b_gnt      <= 1'b0;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            last_owner <= OWNER_B;
            burst_cnt  <= '0;
        end else begin
            a_gnt      <= grant_a;
            b_gnt      <= grant_b;
            // The RAM samples the registered read command on this edge, so its data
            // lands in the cycle where rvalid is now raised.
            a_rvalid   <= a_gnt && !ram_we;
            b_rvalid   <= b_gnt && !ram_we;
            last_owner <= next_owner;
            burst_cnt  <= next_cnt;
            if (grant_a) begin
                ram_we   <= a_we;
                ram_addr <= a_addr;
                ram_din  <= a_wdata;
            end else if (grant_b) begin
                ram_we   <= b_we;
                ram_addr <= b_addr;
                ram_din  <= b_wdata;
            end else begin
                ram_we   <= 1'b0;
            end
        end
    end

    assign rdata = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Purpose: directed, table-driven check of ram_arbiter against a small write-first RAM model.
// Latency: one table row per rising edge; outputs sampled 1 time unit after the edge.
// Backpressure: the rows encode when a losing requester keeps its request up.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_lock, a_we, b_req, b_lock, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] rdata;
    logic        ram_we;
    logic [15:0] ram_addr, ram_din;
    logic [15:0] ram_dout;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.RAM_SIZE(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // Synchronous write-first RAM, 256 words deep (low address byte).
    logic [15:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        ram_dout = 16'h0000;
    end
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_din;
            ram_dout           <= ram_din;
        end else begin
            ram_dout <= mem[ram_addr[7:0]];
        end
    end

    typedef struct {
        string       name;
        logic        rs, ar, al, aw;
        logic [15:0] aa, ad;
        logic        br, bl, bw;
        logic [15:0] ba, bd;
        logic        ea, eb, ewe;
        logic [15:0] eaddr, edin;
        logic        ear, ebr, ckr;
        logic [15:0] erd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic rs,
                                logic ar, logic al, logic aw, logic [15:0] aa, logic [15:0] ad,
                                logic br, logic bl, logic bw, logic [15:0] ba, logic [15:0] bd,
                                logic ea, logic eb, logic ewe, logic [15:0] eaddr, logic [15:0] edin,
                                logic ear, logic ebr, logic ckr, logic [15:0] erd);
        vec_t v;
        v.name = n; v.rs = rs;
        v.ar = ar; v.al = al; v.aw = aw; v.aa = aa; v.ad = ad;
        v.br = br; v.bl = bl; v.bw = bw; v.ba = ba; v.bd = bd;
        v.ea = ea; v.eb = eb; v.ewe = ewe; v.eaddr = eaddr; v.edin = edin;
        v.ear = ear; v.ebr = ebr; v.ckr = ckr; v.erd = erd;
        vecs.push_back(v);
    endfunction

    task automatic chk(string n, int row, logic [15:0] act, logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s row %0d: got %h expected %h", n, row, act, exp);
        end
    endtask

    initial begin
        bit pat_b [10];
        pat_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset; requests during reset are ignored.
        add("rst0",   0, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0);
        add("rst1",   0, 1,0,0,16'h0007,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0);
        // B writes BEEF to 3, A reads it back.
        add("bwr",    1, 0,0,0,16'h0000,16'h0000, 1,0,1,16'h0003,16'hBEEF, 0,1,1,16'h0003,16'hBEEF, 0,0,0,16'h0);
        add("ard",    1, 1,0,0,16'h0003,16'h0000, 0,0,0,16'h0000,16'h0000, 1,0,0,16'h0003,16'h0000, 0,0,0,16'h0);
        add("arv",    1, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0003,16'h0000, 1,0,1,16'hBEEF);
        // Fresh reset, then both request continuously without lock: A,B,A,B...
        add("rst2",   0, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0);
        for (int i = 0; i < 8; i++)
            add("rr", 1, 1,0,0,16'h0020,16'h0000, 1,0,0,16'h0021,16'h0000,
                (i % 2) == 0, (i % 2) == 1, 0, ((i % 2) == 0) ? 16'h0020 : 16'h0021, 16'h0000,
                (i > 0) && ((i % 2) == 1), (i > 0) && ((i % 2) == 0), 0, 16'h0);
        add("rridle", 1, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0021,16'h0000, 0,1,0,16'h0);
        // A locks against a waiting B: A,A,A,A,B,A,A,A,A,B.
        for (int i = 0; i < 10; i++)
            add("lock", 1, 1,1,0,16'h0030,16'h0000, 1,0,0,16'h0031,16'h0000,
                !pat_b[i], pat_b[i], 0, pat_b[i] ? 16'h0031 : 16'h0030, 16'h0000,
                (i > 0) && !pat_b[(i > 0) ? i - 1 : 0], (i > 0) && pat_b[(i > 0) ? i - 1 : 0], 0, 16'h0);
        add("lkidle", 1, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0031,16'h0000, 0,1,0,16'h0);
        // Write from B followed immediately by read from A of the same word.
        add("b2w",    1, 0,0,0,16'h0000,16'h0000, 1,0,1,16'h0010,16'h1234, 0,1,1,16'h0010,16'h1234, 0,0,0,16'h0);
        add("a2r",    1, 1,0,0,16'h0010,16'h0000, 0,0,0,16'h0000,16'h0000, 1,0,0,16'h0010,16'h0000, 0,0,0,16'h0);
        add("a2rv",   1, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0010,16'h0000, 1,0,1,16'h1234);
        // Reset while an A read is in flight: no rvalid, and the next tie goes to A.
        add("a5r",    1, 1,0,0,16'h0003,16'h0000, 0,0,0,16'h0000,16'h0000, 1,0,0,16'h0003,16'h0000, 0,0,0,16'h0);
        add("rst5",   0, 1,0,0,16'h0003,16'h0000, 1,0,0,16'h0041,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0);
        add("tie5",   1, 1,0,0,16'h0040,16'h0000, 1,0,0,16'h0041,16'h0000, 1,0,0,16'h0040,16'h0000, 0,0,0,16'h0);
        add("tie5v",  1, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0040,16'h0000, 1,0,0,16'h0);
        // Idle stretch, then a full-length A burst again.
        for (int i = 0; i < 5; i++)
            add("idle", 1, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0040,16'h0000, 0,0,0,16'h0);
        for (int i = 0; i < 5; i++)
            add("burst6", 1, 1,1,0,16'h0050,16'h0000, 1,0,0,16'h0051,16'h0000,
                i < 4, i == 4, 0, (i < 4) ? 16'h0050 : 16'h0051, 16'h0000, i > 0, 0, 0, 16'h0);
        add("b6v",    1, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,0,16'h0051,16'h0000, 0,1,0,16'h0);

        rst = 1'b0; a_req = 0; a_lock = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_lock = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        @(negedge clk);
        foreach (vecs[k]) begin
            rst    = vecs[k].rs;
            a_req  = vecs[k].ar; a_lock = vecs[k].al; a_we = vecs[k].aw;
            a_addr = vecs[k].aa; a_wdata = vecs[k].ad;
            b_req  = vecs[k].br; b_lock = vecs[k].bl; b_we = vecs[k].bw;
            b_addr = vecs[k].ba; b_wdata = vecs[k].bd;
            @(posedge clk);
            #1;
            chk({vecs[k].name, ".a_gnt"},    k, 16'(a_gnt),    16'(vecs[k].ea));
            chk({vecs[k].name, ".b_gnt"},    k, 16'(b_gnt),    16'(vecs[k].eb));
            chk({vecs[k].name, ".ram_we"},   k, 16'(ram_we),   16'(vecs[k].ewe));
            chk({vecs[k].name, ".ram_addr"}, k, ram_addr,      vecs[k].eaddr);
            chk({vecs[k].name, ".a_rvalid"}, k, 16'(a_rvalid), 16'(vecs[k].ear));
            chk({vecs[k].name, ".b_rvalid"}, k, 16'(b_rvalid), 16'(vecs[k].ebr));
            if (vecs[k].ewe) chk({vecs[k].name, ".ram_din"}, k, ram_din, vecs[k].edin);
            if (vecs[k].ckr) chk({vecs[k].name, ".rdata"},   k, rdata,   vecs[k].erd);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the control unit (port A) and a host/DMA loader (port B) that moves data_in/data_out words in and out of RAM.
- Sits between the requesters and the RAM, and drives the RAM's we/addr/din.
- Grants at most one access per cycle.
- Arbitration is round-robin with an optional bounded burst lock.
- Returns read data with a fixed one-cycle latency after the grant.

Parameters:
- RAM_SIZE, 16, RAM address width in bits (matches the RAM instance).
- MAX_BURST, 4, maximum consecutive grants to one locked requester while the other is waiting (1..15).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- a_req  in  1  port A (control unit) access request; held until a_gnt.
- a_lock  in  1  port A asks to keep the grant on following cycles.
- a_we  in  1  port A write enable (1 = write, 0 = read).
- a_addr  in  RAM_SIZE  port A address.
- a_wdata  in  16  port A write data.
- a_gnt  out  1  one-cycle pulse: port A access issued this cycle.
- a_rvalid  out  1  port A read data valid on rdata.
- b_req, b_lock, b_we, b_addr, b_wdata, b_gnt, b_rvalid  as port A, for port B (host/DMA).
- rdata  out  16  read data, valid when a_rvalid or b_rvalid.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_SIZE  RAM address.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data; synchronous RAM, valid one cycle after its address.

Behaviour:
- Reset (rst=0 at a rising edge) forces these outputs to 0: a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_addr, ram_din.
- Reset sets last_owner=B (so A wins the first tie) and burst_cnt=0.
- A reset mid-burst, or with a read outstanding, drops everything: no rvalid follows.
- Decision at each edge, evaluated on the requests sampled at that edge:
  - No requests: idle cycle. ram_we=0, gnt=0; ram_addr/ram_din hold their last value.
  - One request: that port is granted.
  - Both requesting, no lock in force: grant goes to the port other than last_owner.
  - Lock in force (last_owner's req and lock are both 1, and burst_cnt < MAX_BURST): grant last_owner again.
  - When burst_cnt reaches MAX_BURST with the other port requesting, grant the other port.
- Grant timing: the grant registers x_gnt=1, ram_we=x_we, ram_addr=x_addr, ram_din=x_wdata. All are visible in the cycle after the deciding edge.
- Requester handshake: a requester sees x_gnt=1 and must update or drop req on that same edge. Holding req high means a new access.
- Back-to-back grants are allowed, so 1 access per cycle at full throughput.
- burst_cnt counts consecutive grants to the same owner:
  - reset to 1 on an owner change;
  - saturates at MAX_BURST;
  - cleared on an idle cycle.
- The lock is honoured only while the other port is requesting. An unopposed requester is granted indefinitely.
- Read return: x_rvalid pulses exactly one cycle after an x_gnt with x_we=0. rdata = ram_dout (combinational pass-through).
- A grant with x_we=1 produces no rvalid. a_rvalid and b_rvalid are never 1 together.
- Writes complete in RAM at the edge ending the gnt cycle.
- A read granted immediately after a write to the same address returns the new data; the RAM is write-first.
- Simultaneous events:
  - A new grant in the same cycle as the rvalid of the previous read is legal.
  - A lock from the non-owner is ignored.
- Address and data pass through unmodified. No width conversion; ram_addr is exactly RAM_SIZE bits.

Test Plan:
1. Reset, then A alone reads addr 0x0003 after B wrote 0xBEEF there: a_gnt one cycle after the edge, a_rvalid the next cycle, rdata=0xBEEF; b_rvalid stays 0.
2. A and B both request continuously, no lock, from reset: grants alternate A,B,A,B over 8 cycles with no idle cycles.
3. A requests with lock=1 for 10 cycles while B requests, MAX_BURST=4: grants A,A,A,A,B,A,A,A,A,B.
4. B writes 0x1234 to 0x0010 in cycle N, then A reads 0x0010 in cycle N+1: ram_we=1 only in the B grant cycle; A gets rdata=0x1234 with a_rvalid.
5. rst driven low for one edge while an A read is granted: next cycle a_rvalid=0 and all gnt/ram_we=0; the first tie after reset goes to A.
6. No requests for 5 cycles after traffic: ram_we=0, no gnt or rvalid pulses; burst_cnt clears, so a subsequent A lock burst again gets the full MAX_BURST grants.
